// File: rtl/fifo_pack_pkg.sv
// fifo_pack_pkg
//   Shared defaults and types for the padded-frame byte-to-word packer.
//   Frame format on the byte stream: LANES data bytes (MSB first) followed
//   by FRAME-LANES pad bytes.
package fifo_pack_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int LANES_DEF      = 4;
  localparam int FRAME_DEF      = 7;
  localparam int DEPTH_DEF      = 4;

  typedef logic [$clog2(FRAME_DEF)-1:0]         slot_t;
  typedef logic [DATA_WIDTH_DEF*LANES_DEF-1:0]  word_t;

endpackage

// File: rtl/fifo_pack_out1_word_fifo.sv
// word_fifo
//   Synchronous first-word-fall-through FIFO. The head entry is presented
//   on pop_data whenever the FIFO is non-empty (zero when empty).
//   DEPTH need not be a power of two; pointers wrap by compare.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   push       write push_data (ignored when full)
//   push_data  entry to write
//   pop        advance head (ignored when empty)
//   pop_data   head entry
//   full       DEPTH entries stored
//   empty      no entries stored
//   count      occupancy
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fifo_pack_out1.sv
// fifo_pack_out1
//   Drain end of the padded-frame byte stream. Consumes FRAME-byte frames
//   (LANES data bytes MSB first, then pad bytes), strips the pad, packs the
//   data bytes into one word and buffers words in a DEPTH-entry FWFT FIFO.
//   Optional macro FIFO_PACK_PAD_CHECK_EN: when defined, any accepted
//   nonzero pad byte sets the sticky pad_err flag; otherwise pad_err is 0.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   in_data valid
//   in_data    byte stream in frame order
//   in_ready   byte accepted when in_valid && in_ready
//   out_valid  head word available
//   out_data   head word, slot 0 in the MSBs
//   out_ready  consumer pops when out_valid && out_ready
//   full       word FIFO full
//   empty      word FIFO empty
//   count      word FIFO occupancy
//   pad_err    sticky nonzero-pad flag
module fifo_pack_out1
  import fifo_pack_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int FRAME      = FRAME_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH*LANES-1:0]   out_data,
  input  logic                          out_ready,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          pad_err
);

  localparam int WW = DATA_WIDTH*LANES;
  localparam int SW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [SW-1:0] LAST_DATA = SW'(LANES-1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(FRAME-1);

  logic [SW-1:0] slot;
  logic [WW-1:0] asm_q;
  logic [WW-1:0] push_word;
  logic          last_data;
  logic          is_data;
  logic          accept;
  logic          push;

  assign last_data = (slot == LAST_DATA);
  assign is_data   = (slot < SW'(LANES));
  // Only the final data byte can stall; it is the one that needs FIFO room.
  // Built from registered state only, so out_ready never reaches in_ready.
  assign in_ready  = !(last_data && full);
  assign accept    = in_valid && in_ready;
  assign push      = accept && last_data;
  assign push_word = {asm_q[WW-DATA_WIDTH-1:0], in_data};
  assign out_valid = !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot  <= '0;
      asm_q <= '0;
    end else if (accept) begin
      slot <= (slot == LAST_SLOT) ? '0 : slot + SW'(1);
      if (is_data) asm_q <= {asm_q[WW-DATA_WIDTH-1:0], in_data};
    end
  end

`ifdef FIFO_PACK_PAD_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pad_err <= 1'b0;
    end else if (accept && !is_data && (in_data != '0)) begin
      pad_err <= 1'b1;
    end
  end
`else
  assign pad_err = 1'b0;
`endif

  word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WW)
  ) u_word_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

endmodule

// File: tb/tb_fifo_pack_out1.sv
module tb_fifo_pack_out1;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        pad_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [31:0] q[$];
  logic        rand_on = 1'b0;

`ifdef FIFO_PACK_PAD_CHECK_EN
  localparam logic PAD_ERR_EXP = 1'b1;
`else
  localparam logic PAD_ERR_EXP = 1'b0;
`endif

  fifo_pack_out1 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .pad_err   (pad_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: a pop happens at the next rising edge when both are high.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("empty_vs_count", empty, (count == 3'd0));
      check("full_vs_count", full, (count == 3'd4));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_word", out_data, 32'hxxxx_xxxx);
        end else begin
          check("out_word", out_data, q.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_wait", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w);
    q.push_back(w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    for (int i = 0; i < 3; i++) send_byte(8'h00);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || !empty) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", empty, 1);
    check("drain_queue", q.size(), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Random consumer for the wrap test.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_on) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_pad_err", pad_err, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single frame with immediate consumer.
    out_ready = 1'b1;
    q.push_back(32'h11223344);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("t1_not_yet_valid", out_valid, 0);
    send_byte(8'h44);
    check("t1_valid_latency", out_valid, 1);
    check("t1_head", out_data, 32'h11223344);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("t1_count_after_pop", count, 0);
    check("t1_empty_after_pop", empty, 1);
    out_ready = 1'b0;

    // Back-to-back, consumer stalled: 4 fill the FIFO, 5th stalls on slot 3.
    for (int f = 0; f < 4; f++) send_frame(32'hA0B0C000 + 32'(f));
    check("t2_count_full", count, 4);
    check("t2_full", full, 1);
    check("t2_ready_slot0", in_ready, 1);
    q.push_back(32'hA0B0C004);
    send_byte(8'hA0); send_byte(8'hB0); send_byte(8'hC0);
    check("t2_ready_slot3_full", in_ready, 0);
    out_ready = 1'b1;
    send_byte(8'h04);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    drain();

    // Simultaneous push and pop with two entries held.
    send_frame(32'hB0000001);
    send_frame(32'hB0000002);
    check("t3_count2", count, 2);
    q.push_back(32'hB0000003);
    send_byte(8'hB0); send_byte(8'h00); send_byte(8'h00);
    out_ready = 1'b1;
    send_byte(8'h03);
    out_ready = 1'b0;
    check("t3_count_stays", count, 2);
    check("t3_head_advanced", out_data, 32'hB0000002);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    drain();

    // Reset mid-frame discards the partial frame.
    out_ready = 1'b1;
    send_byte(8'h01); send_byte(8'h02);
    rst = 1'b0;
    #3;
    check("t4_rst_empty", empty, 1);
    check("t4_rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_frame(32'hAABBCCDD);
    drain();

    // Long stream with random consumer: several pointer wraps.
    rand_on = 1'b1;
    for (int f = 0; f < 10; f++) send_frame($urandom());
    rand_on = 1'b0;
    drain();

    // Nonzero pad byte in slot 5.
    out_ready = 1'b1;
    q.push_back(32'h01020304);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h00);
    check("t6_pad_err_before", pad_err, 0);
    send_byte(8'h01);
    check("t6_pad_err_set", pad_err, 32'(PAD_ERR_EXP));
    send_byte(8'h00);
    send_frame(32'h05060708);
    check("t6_pad_err_held", pad_err, 32'(PAD_ERR_EXP));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_pack_out1.md
Name: fifo_pack_out1

Overview:
- Byte-to-word packer with output FIFO, i.e. the drain end of the padded-frame byte stream.
- The upstream input FIFO expands each 32-bit word into a 7-byte frame: 4 data bytes MSB-first, then 3 zero pad bytes.
- This block consumes that frame format from the compute array, strips the pad bytes, reassembles 32-bit words and buffers them for a word-wide consumer.

Parameters:
- DATA_WIDTH, 8, width of one byte lane.
- LANES, 4, data bytes per frame (word = DATA_WIDTH*LANES bits).
- FRAME, 7, total bytes per frame; slots LANES..FRAME-1 are pad.
- DEPTH, 4, word entries in the output FIFO.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DATA_WIDTH  byte stream, frame order.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- out_valid  output  1  out_data holds the head word.
- out_data  output  DATA_WIDTH*LANES  packed word, slot0 in MSBs.
- out_ready  input  1  consumer pops when out_valid && out_ready.
- full  output  1  word FIFO holds DEPTH entries.
- empty  output  1  word FIFO holds 0 entries.
- count  output  $clog2(DEPTH+1)  word FIFO occupancy.
- pad_err  output  1  sticky nonzero-pad flag (see Optional Feature).

Behaviour:
- Reset (rst low, async, any cycle, including mid-frame):
  - slot=0, assembly register=0, FIFO pointers/count=0.
  - out_valid=0, out_data=0, empty=1, full=0, pad_err=0.
  - A partial frame is discarded.
- Slot counter 0..FRAME-1, advances by 1 on each accepted byte, wraps FRAME-1 -> 0.
- Slots 0..LANES-1: shift the byte into the assembly register MSB-first (slot0 -> bits [31:24] at defaults).
- Slots LANES..FRAME-1: byte accepted and discarded; slot still advances.
- Push: accepting slot LANES-1 pushes {assembly[23:0], in_data} into the word FIFO in the same edge.
- in_ready:
  - = !(slot==LANES-1 && full).
  - Depends on registered state only; no combinational path from out_ready.
  - Pad slots and slots 0..LANES-2 are always ready.
- Pop: out_valid=!empty; out_data = head entry (first-word fall-through). Pop on out_valid && out_ready.
- Push and pop in the same cycle: count unchanged, both pointers advance. Permitted whenever not full; when full, push is blocked by in_ready regardless of pop.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two; wrap by compare-to-DEPTH-1, not by bit truncation.
- Latency: last data byte (slot LANES-1) accepted at edge N -> out_valid=1 after edge N; head word is visible in the same cycle.
- Pop on empty: ignored, no pointer change.
- Throughput: one word per FRAME accepted bytes; sustained rate 1 word / 7 cycles at defaults.

Optional Feature:
- Macro: FIFO_PACK_PAD_CHECK_EN.
- Defined:
  - On every accepted pad-slot byte != 0, pad_err sets the following edge.
  - pad_err stays set until reset.
  - Data path is unaffected.
- Undefined: pad_err tied to 0; no compare logic.

Decomposition:
- Package fifo_pack_pkg:
  - localparams LANES and FRAME defaults.
  - typedef slot_t = logic [$clog2(FRAME)-1:0].
  - typedef word_t = logic [DATA_WIDTH*LANES-1:0].
- One sub-module, word_fifo:
  - Parameterized DEPTH and WIDTH.
  - Synchronous FWFT FIFO with push/pop/full/empty/count, async active-low reset.
  - The top level holds only the slot counter, assembly register, in_ready and pad check.

Test Plan:
- Single frame: bytes 0x11,0x22,0x33,0x44,0,0,0 with out_ready=1 -> out_valid one cycle after the 0x44 byte; out_data=0x11223344; count returns to 0 after the pop.
- Back-to-back: 5 frames with out_ready=0 and DEPTH=4 -> 4 words stored, full=1. in_ready drops only at slot 3 of frame 5. After raising out_ready, all 5 words are delivered in order with no loss.
- Simultaneous push/pop: count=2, push and pop on the same edge -> count stays 2, head advances to the next word.
- Reset mid-frame: assert rst after 2 bytes of a frame, then send a full frame 0xAABBCCDD -> output is exactly 0xAABBCCDD; no stale bytes.
- Pointer wrap: 10 frames streamed with random out_ready -> output sequence matches input order across multiple wraps; empty/full stay consistent with count.
- With FIFO_PACK_PAD_CHECK_EN: pad byte 0x01 in slot 5 -> pad_err=1 the next cycle and held. Without the macro, the same stimulus -> pad_err stays 0.
